// File: rtl/product_accumulator.sv
// product_accumulator: sums NUM_SAMPLES 4-bit products with 8-bit saturation and valid/ready handshakes.
// Optional peak tracking is enabled by defining PRODUCT_ACC_PEAK_EN.
module product_accumulator #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p0,
    input  logic       p1,
    input  logic       p2,
    input  logic       p3,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sum,
    output logic [7:0] count,
    output logic       overflow,
    output logic [3:0] peak
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [7:0] LAST = 8'(NUM_SAMPLES);
    state_t state, state_nx;
    logic [3:0] product;
    logic [8:0] sum_add;
    logic [7:0] count_nx;
    logic accept, consume;
    assign product   = {p3, p2, p1, p0};
    assign in_ready  = state != DONE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign sum_add   = {1'b0, sum} + {5'd0, product};
    assign count_nx  = count + 8'd1;
    always_comb begin
        state_nx = state;
        if (clear || consume)
            state_nx = IDLE;
        else if (accept)
            state_nx = (count_nx == LAST) ? DONE : ACCUM;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // Carry out of the 9-bit add is the saturation condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= 8'd0;
            count    <= 8'd0;
            overflow <= 1'b0;
        end else if (clear || consume) begin
            sum      <= 8'd0;
            count    <= 8'd0;
            overflow <= 1'b0;
        end else if (accept) begin
            sum      <= sum_add[8] ? 8'hff : sum_add[7:0];
            count    <= count_nx;
            overflow <= overflow | sum_add[8];
        end
    end
`ifdef PRODUCT_ACC_PEAK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak <= 4'd0;
        else if (clear || consume)
            peak <= 4'd0;
        else if (accept)
            peak <= (product > peak) ? product : peak;
    end
`else
    assign peak = 4'd0;
`endif
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: three instances (NUM_SAMPLES 4, 30, 1) on shared stimulus,
// checked every cycle against a plain-arithmetic model plus directed literal expectations.
module tb_product_accumulator;
    localparam int NI = 3;
    localparam int NS [NI] = '{4, 30, 1};
    logic clk;
    logic rst;
    logic [3:0] prod;
    logic in_valid, clear, out_ready;
    logic       d_in_ready [NI];
    logic       d_out_valid [NI];
    logic [7:0] d_sum [NI];
    logic [7:0] d_count [NI];
    logic       d_overflow [NI];
    logic [3:0] d_peak [NI];
    int vectors = 0;
    int miscompares = 0;
    int  m_tsum [NI] = '{0, 0, 0};
    int  m_cnt  [NI] = '{0, 0, 0};
    int  m_pk   [NI] = '{0, 0, 0};
    bit  m_done [NI] = '{0, 0, 0};
    product_accumulator #(.NUM_SAMPLES(4)) u0 (
        .clk(clk), .rst(rst), .p0(prod[0]), .p1(prod[1]), .p2(prod[2]), .p3(prod[3]),
        .in_valid(in_valid), .in_ready(d_in_ready[0]), .clear(clear),
        .out_valid(d_out_valid[0]), .out_ready(out_ready), .sum(d_sum[0]),
        .count(d_count[0]), .overflow(d_overflow[0]), .peak(d_peak[0]));
    product_accumulator #(.NUM_SAMPLES(30)) u1 (
        .clk(clk), .rst(rst), .p0(prod[0]), .p1(prod[1]), .p2(prod[2]), .p3(prod[3]),
        .in_valid(in_valid), .in_ready(d_in_ready[1]), .clear(clear),
        .out_valid(d_out_valid[1]), .out_ready(out_ready), .sum(d_sum[1]),
        .count(d_count[1]), .overflow(d_overflow[1]), .peak(d_peak[1]));
    product_accumulator #(.NUM_SAMPLES(1)) u2 (
        .clk(clk), .rst(rst), .p0(prod[0]), .p1(prod[1]), .p2(prod[2]), .p3(prod[3]),
        .in_valid(in_valid), .in_ready(d_in_ready[2]), .clear(clear),
        .out_valid(d_out_valid[2]), .out_ready(out_ready), .sum(d_sum[2]),
        .count(d_count[2]), .overflow(d_overflow[2]), .peak(d_peak[2]));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int exp_peak(input int v);
`ifdef PRODUCT_ACC_PEAK_EN
        return v;
`else
        return 0;
`endif
    endfunction
    // Model: true running sum as an integer; outputs derived from it.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst || clear || (m_done[i] && out_ready)) begin
                m_tsum[i] = 0;
                m_cnt[i]  = 0;
                m_pk[i]   = 0;
                m_done[i] = 0;
            end else if (!m_done[i] && in_valid) begin
                m_tsum[i] += int'(prod);
                m_cnt[i]  += 1;
                if (int'(prod) > m_pk[i]) m_pk[i] = int'(prod);
                if (m_cnt[i] == NS[i]) m_done[i] = 1;
            end
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.out_valid", i), int'(d_out_valid[i]), int'(m_done[i]));
            chk($sformatf("u%0d.in_ready", i), int'(d_in_ready[i]), int'(!m_done[i]));
            chk($sformatf("u%0d.sum", i), int'(d_sum[i]), (m_tsum[i] > 255) ? 255 : m_tsum[i]);
            chk($sformatf("u%0d.count", i), int'(d_count[i]), m_cnt[i]);
            chk($sformatf("u%0d.overflow", i), int'(d_overflow[i]), int'(m_tsum[i] > 255));
            chk($sformatf("u%0d.peak", i), int'(d_peak[i]), exp_peak(m_pk[i]));
        end
    end
    task automatic drive(input bit v, input int p, input bit c, input bit r);
        in_valid  = v;
        prod      = 4'(p);
        clear     = c;
        out_ready = r;
        @(negedge clk);
    endtask
    initial begin
        rst = 1;
        prod = 0;
        in_valid = 0;
        clear = 0;
        out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset.sum", int'(d_sum[0]), 0);
        chk("reset.count", int'(d_count[0]), 0);
        chk("reset.out_valid", int'(d_out_valid[0]), 0);
        chk("reset.in_ready", int'(d_in_ready[0]), 1);
        // 3,6,9,4 back-to-back into NUM_SAMPLES=4
        drive(1, 3, 0, 1);
        drive(1, 6, 0, 1);
        drive(1, 9, 0, 1);
        drive(1, 4, 0, 1);
        chk("d028.out_valid", int'(d_out_valid[0]), 1);
        chk("d028.sum", int'(d_sum[0]), 22);
        chk("d028.count", int'(d_count[0]), 4);
        chk("d028.overflow", int'(d_overflow[0]), 0);
        chk("d028.peak", int'(d_peak[0]), exp_peak(9));
        drive(0, 0, 0, 1);
        chk("d028.consumed", int'(d_sum[0]), 0);
        drive(0, 0, 1, 0);
        // Saturation on NUM_SAMPLES=30 with product 9
        for (int k = 1; k <= 30; k++) begin
            drive(1, 9, 0, 0);
            if (k == 28) chk("d029.sum28", int'(d_sum[1]), 252);
            if (k == 28) chk("d029.ovf28", int'(d_overflow[1]), 0);
            if (k == 29) chk("d029.sum29", int'(d_sum[1]), 255);
            if (k == 29) chk("d029.ovf29", int'(d_overflow[1]), 1);
        end
        chk("d029.out_valid", int'(d_out_valid[1]), 1);
        chk("d029.count", int'(d_count[1]), 30);
        chk("d029.sum", int'(d_sum[1]), 255);
        chk("d029.overflow", int'(d_overflow[1]), 1);
        drive(0, 0, 1, 0);
        // DONE stalls with out_ready low while inputs keep coming
        repeat (4) drive(1, 5, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 5, 0, 0);
            chk("d030.in_ready", int'(d_in_ready[0]), 0);
            chk("d030.sum", int'(d_sum[0]), 20);
            chk("d030.count", int'(d_count[0]), 4);
        end
        drive(0, 0, 0, 1);
        chk("d030.idle_valid", int'(d_out_valid[0]), 0);
        chk("d030.idle_sum", int'(d_sum[0]), 0);
        // clear wins over a simultaneous accept
        drive(1, 4, 0, 0);
        drive(1, 4, 0, 0);
        chk("d031.sum8", int'(d_sum[0]), 8);
        chk("d031.count2", int'(d_count[0]), 2);
        drive(1, 7, 1, 0);
        chk("d031.sum", int'(d_sum[0]), 0);
        chk("d031.count", int'(d_count[0]), 0);
        drive(1, 1, 0, 0);
        chk("d031.restart", int'(d_count[0]), 1);
        // async reset between edges
        drive(1, 2, 0, 0);
        drive(1, 3, 0, 0);
        chk("d032.sum_pre", int'(d_sum[0]), 6);
        #2 rst = 1;
        #1;
        chk("d032.async_sum", int'(d_sum[0]), 0);
        chk("d032.async_count", int'(d_count[0]), 0);
        chk("d032.async_sum30", int'(d_sum[1]), 0);
        @(negedge clk);
        rst = 0;
        drive(1, 1, 0, 0);
        chk("d032.count1", int'(d_count[0]), 1);
        drive(1, 2, 0, 0);
        drive(1, 3, 0, 0);
        drive(1, 4, 0, 0);
        chk("d032.sum", int'(d_sum[0]), 10);
        chk("d032.done", int'(d_out_valid[0]), 1);
        // single-sample instance
        drive(0, 0, 1, 0);
        drive(1, 9, 0, 0);
        chk("d033.out_valid", int'(d_out_valid[2]), 1);
        chk("d033.sum", int'(d_sum[2]), 9);
        chk("d033.count", int'(d_count[2]), 1);
        chk("d033.in_ready", int'(d_in_ready[2]), 0);
        // randomized traffic with rare clears and async reset pulses
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            prod      = 4'($urandom_range(0, 9));
            clear     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1;
                #2 rst = 0;
            end
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 4, number of products summed per result (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have ports p0, p1, p2, p3, input, 1 each, the 4-bit product from the 2-bit multiplier (p0 = LSB), range 0..9.
REQ-005 SHALL have port in_valid, input, 1, product bits valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts a product this cycle.
REQ-007 SHALL have port clear, input, 1, synchronous abort of the current accumulation.
REQ-008 SHALL have port out_valid, output, 1, result on sum/count/overflow is valid.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port sum, output, 8, running or final accumulated sum.
REQ-011 SHALL have port count, output, 8, number of products accepted so far.
REQ-012 SHALL have port overflow, output, 1, sticky saturation flag.
REQ-013 SHALL have port peak, output, 4, largest product accepted in the current accumulation.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-015 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in DONE (combinational from state).
REQ-016 SHALL accept a product when in_valid && in_ready at a clock edge: sum and count update on that edge, visible the next cycle (1-cycle latency).
REQ-017 SHALL compute sum as a zero-extended add; if the true result exceeds 255, sum SHALL saturate at 255 and overflow SHALL set and stay set until the result is consumed, clear, or rst.
REQ-018 SHALL transition IDLE->ACCUM on the first accepted product when NUM_SAMPLES > 1.
REQ-019 SHALL transition IDLE or ACCUM->DONE on the edge that accepts the NUM_SAMPLES-th product, including the first product when NUM_SAMPLES = 1.
REQ-020 SHALL assert out_valid only in DONE, holding sum, count, overflow and peak stable until the handshake.
REQ-021 SHALL, on out_valid && out_ready in DONE, go to IDLE on that edge and zero sum, count, overflow and peak.
REQ-022 SHALL, when clear = 1, go to IDLE and zero sum, count, overflow and peak on that edge, in any state.
REQ-023 SHALL give clear priority over a simultaneous input accept or output handshake; that product is dropped and that result is discarded.
REQ-024 SHALL ignore in_valid in DONE, with no change to sum or count.

Reset
REQ-025 SHALL, while rst = 1, force state IDLE, sum = 0, count = 0, overflow = 0, peak = 0 and out_valid = 0 immediately, without waiting for clk.
REQ-026 SHALL, on reset asserted mid-accumulation, discard all partial results; the first accepted product after release starts a new accumulation with count = 1.

Configuration
REQ-027 SHALL use macro PRODUCT_ACC_PEAK_EN: when defined, peak updates on each accept to max(peak, product); when undefined, the peak register is not built and peak is tied to 0.

Verification
REQ-028 Directed: NUM_SAMPLES=4, products 3,6,9,4 back-to-back with out_ready=1 -> out_valid pulses one cycle after the 4th accept, sum=22, count=4, overflow=0, peak=9 (PEAK_EN defined) or 0 (undefined).
REQ-029 Directed: NUM_SAMPLES=30, product 9 every cycle -> sum saturates at 255 after the 29th accept (true sum 261), overflow=1, final count=30.
REQ-030 Directed: DONE with out_ready=0 for 5 cycles while in_valid=1, product=5 -> in_ready=0, outputs frozen; out_ready=1 -> IDLE next cycle with sum=0.
REQ-031 Directed: clear=1 in the same cycle as an accept of product 7 after sum=8, count=2 -> next cycle IDLE, sum=0, count=0; product 7 not counted.
REQ-032 Directed: rst asserted between clock edges mid-ACCUM -> outputs zero before the next edge; after release, products 1,2,3,4 yield sum=10.
REQ-033 Directed: NUM_SAMPLES=1, product 9 accepted -> DONE next cycle, sum=9, count=1, in_ready=0.
